// File: rtl/memory_controller.sv
// Byte-serial memory controller: arbitrates instruction fetch and LSB accesses
// onto the unified 8-bit RAM bus, assembling/splitting little-endian words.
module memory_controller #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        fetch_start,
  input  logic [31:0] pc_in,
  output logic        is_idle,
  output logic        finish_fetch,
  output logic [31:0] instruction_out,
  output logic [31:0] instruction_pc_out,
  input  logic        lsb_start,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_data_in,
  output logic        lsb_finish,
  output logic [31:0] lsb_data_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, IF_READ, LSB_READ, LSB_WRITE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc, last_ext, last_inc;
  logic [1:0]          last, last_nxt, req_last;
  logic [WORD_W-1:0]   base, base_nxt;
  logic [WORD_W-1:0]   wdata, wdata_nxt;
  logic [WORD_W-1:0]   rbuf, rbuf_nxt, rbuf_cap;
  logic [WORD_W-1:0]   inst_nxt, inst_pc_nxt, ldata_nxt, addr_nxt;
  logic [BYTE_W-1:0]   dout_nxt, wbyte_next;
  logic                wr_en, wr_en_nxt;
  logic                fin_if, fin_if_nxt;
  logic                fin_lsb, fin_lsb_nxt;
  logic                idle_nxt;
  logic                io_blocked;

  // Byte index of the last byte of a request; the illegal 2'b10 length maps to a word.
  assign req_last = (lsb_len == 2'b00) ? 2'b00 :
                    (lsb_len == 2'b01) ? 2'b01 : 2'b11;

  assign cnt_inc  = cnt + CNT_W'(1);
  assign last_ext = CNT_W'(last);
  assign last_inc = last_ext + CNT_W'(1);

  assign io_blocked = (mem_a[17:16] == IO_ADDR_HI) && io_buffer_full;

  // Strobes are qualified by rdy so a frozen cycle never writes or reports completion.
  assign mem_wr       = wr_en & rdy_in & ~io_blocked;
  assign finish_fetch = fin_if & rdy_in;
  assign lsb_finish   = fin_lsb & rdy_in;

  // Read buffer with the byte arriving this cycle (address issued last cycle) merged in.
  always_comb begin
    rbuf_cap = rbuf;
    for (int i = 0; i < 4; i++) begin
      if (cnt == CNT_W'(i + 1)) rbuf_cap[BYTE_W*i +: BYTE_W] = mem_din;
    end
  end

  // Store byte to present once the current one is accepted.
  always_comb begin
    wbyte_next = wdata[BYTE_W-1:0];
    for (int i = 0; i < 4; i++) begin
      if (cnt_inc == CNT_W'(i)) wbyte_next = wdata[BYTE_W*i +: BYTE_W];
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_nxt    = last;
    base_nxt    = base;
    wdata_nxt   = wdata;
    rbuf_nxt    = rbuf;
    inst_nxt    = instruction_out;
    inst_pc_nxt = instruction_pc_out;
    ldata_nxt   = lsb_data_out;
    addr_nxt    = mem_a;
    dout_nxt    = mem_dout;
    wr_en_nxt   = 1'b0;
    fin_if_nxt  = 1'b0;
    fin_lsb_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        // LSB has priority; roll_back only suppresses a fetch accept.
        if (lsb_start) begin
          state_nxt = lsb_wr ? LSB_WRITE : LSB_READ;
          cnt_nxt   = '0;
          last_nxt  = req_last;
          base_nxt  = lsb_addr;
          addr_nxt  = lsb_addr;
          rbuf_nxt  = '0;
          wdata_nxt = lsb_data_in;
          if (lsb_wr) begin
            dout_nxt  = lsb_data_in[BYTE_W-1:0];
            wr_en_nxt = 1'b1;
          end
        end else if (fetch_start && !roll_back) begin
          state_nxt   = IF_READ;
          cnt_nxt     = '0;
          last_nxt    = 2'b11;
          base_nxt    = pc_in;
          addr_nxt    = pc_in;
          inst_pc_nxt = pc_in;
          rbuf_nxt    = '0;
        end
      end

      IF_READ, LSB_READ: begin
        if (state == IF_READ && roll_back) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          rbuf_nxt = rbuf_cap;
          cnt_nxt  = cnt_inc;
          if (cnt < last_ext) addr_nxt = base + WORD_W'(cnt_inc);
          if (cnt == last_inc) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            if (state == IF_READ) begin
              inst_nxt   = rbuf_cap;
              fin_if_nxt = 1'b1;
            end else begin
              ldata_nxt   = rbuf_cap;
              fin_lsb_nxt = 1'b1;
            end
          end
        end
      end

      LSB_WRITE: begin
        wr_en_nxt = 1'b1;
        // A full IO buffer stalls the byte in place until it drains.
        if (!io_blocked) begin
          if (cnt == last_ext) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            wr_en_nxt   = 1'b0;
            fin_lsb_nxt = 1'b1;
          end else begin
            cnt_nxt  = cnt_inc;
            addr_nxt = base + WORD_W'(cnt_inc);
            dout_nxt = wbyte_next;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign idle_nxt = (state_nxt == IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= IDLE;
      cnt                <= '0;
      last               <= '0;
      base               <= '0;
      wdata              <= '0;
      rbuf               <= '0;
      is_idle            <= 1'b1;
      instruction_out    <= '0;
      instruction_pc_out <= '0;
      lsb_data_out       <= '0;
      mem_a              <= '0;
      mem_dout           <= '0;
      wr_en              <= 1'b0;
      fin_if             <= 1'b0;
      fin_lsb            <= 1'b0;
    end else if (rdy_in) begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      last               <= last_nxt;
      base               <= base_nxt;
      wdata              <= wdata_nxt;
      rbuf               <= rbuf_nxt;
      is_idle            <= idle_nxt;
      instruction_out    <= inst_nxt;
      instruction_pc_out <= inst_pc_nxt;
      lsb_data_out       <= ldata_nxt;
      mem_a              <= addr_nxt;
      mem_dout           <= dout_nxt;
      wr_en              <= wr_en_nxt;
      fin_if             <= fin_if_nxt;
      fin_lsb            <= fin_lsb_nxt;
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Testbench for memory_controller: byte RAM model plus a byte-level reference
// memory; directed scenarios followed by randomized fetch/load/store traffic.
module tb_memory_controller;

  localparam logic [1:0] IO_HI = 2'b11;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, roll_back, fetch_start;
  logic [31:0] pc_in;
  logic        is_idle, finish_fetch;
  logic [31:0] instruction_out, instruction_pc_out;
  logic        lsb_start, lsb_wr;
  logic [31:0] lsb_addr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_data_in;
  logic        lsb_finish;
  logic [31:0] lsb_data_out;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  memory_controller #(.IO_ADDR_HI(IO_HI)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .fetch_start(fetch_start), .pc_in(pc_in), .is_idle(is_idle),
    .finish_fetch(finish_fetch), .instruction_out(instruction_out),
    .instruction_pc_out(instruction_pc_out), .lsb_start(lsb_start), .lsb_wr(lsb_wr),
    .lsb_addr(lsb_addr), .lsb_len(lsb_len), .lsb_data_in(lsb_data_in),
    .lsb_finish(lsb_finish), .lsb_data_out(lsb_data_out), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  bit [7:0] rom  [bit [31:0]];
  bit [7:0] ram  [bit [31:0]];
  bit [7:0] refm [bit [31:0]];

  function automatic bit [7:0] init_byte(input bit [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  function automatic bit [7:0] rom_rd(input bit [31:0] a);
    return rom.exists(a) ? rom[a] : init_byte(a);
  endfunction

  function automatic bit [7:0] ram_rd(input bit [31:0] a);
    return ram.exists(a) ? ram[a] : rom_rd(a);
  endfunction

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return refm.exists(a) ? refm[a] : rom_rd(a);
  endfunction

  // Little-endian, zero-extended word the reference memory holds at a..a+n-1.
  function automatic logic [31:0] exp_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(a + 32'(i));
    return w;
  endfunction

  // RAM frozen together with the system while rdy is low; data one cycle after address.
  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= ram_rd(mem_a);
    if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk_in);
    #1;
  endtask

  task automatic preset(input logic [31:0] a, input logic [7:0] v);
    rom[a] = v;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 32 && !is_idle; i++) next();
    chk("wait_idle", 32'(is_idle), 32'd1);
  endtask

  task automatic issue_fetch(input logic [31:0] pc);
    wait_idle();
    fetch_start = 1'b1;
    pc_in = pc;
    next();
    fetch_start = 1'b0;
  endtask

  task automatic issue_lsb(input logic wr, input logic [31:0] a, input logic [1:0] len,
                           input logic [31:0] d);
    wait_idle();
    lsb_start = 1'b1;
    lsb_wr = wr;
    lsb_addr = a;
    lsb_len = len;
    lsb_data_in = d;
    next();
    lsb_start = 1'b0;
  endtask

  // Starts in cycle 0 after accept; returns in the finish cycle (or after an abort).
  task automatic run_read(input bit fetch, input logic [31:0] a, input int n,
                          input int stall_at, input int stall_n, input int rb_at,
                          output int fin_cyc);
    logic [31:0] expw;
    logic        pulse;
    int p;
    bit done;
    expw = exp_word(a, n);
    p = 0;
    done = 0;
    fin_cyc = -1;
    for (int c = 0; c < 64 && !done; c++) begin
      rdy_in = !(c >= stall_at && c < stall_at + stall_n);
      roll_back = (c == rb_at);
      #1;
      pulse = fetch ? finish_fetch : lsb_finish;
      if (p == n + 1) begin
        if (rdy_in) begin
          chk("rd_pulse", 32'(pulse), 32'd1);
          chk("rd_data", fetch ? instruction_out : lsb_data_out, expw);
          if (fetch) chk("fetch_pc", instruction_pc_out, a);
          chk("rd_finish_idle", 32'(is_idle), 32'd1);
          fin_cyc = c;
          done = 1;
        end else begin
          chk("rd_stalled_pulse", 32'(pulse), 32'd0);
        end
      end else begin
        chk("rd_busy_pulse", 32'(pulse), 32'd0);
        chk("rd_busy_idle", 32'(is_idle), 32'd0);
        chk("rd_mem_wr", 32'(mem_wr), 32'd0);
        if (p < n) chk("rd_addr", mem_a, a + 32'(p));
        if (fetch && roll_back && rdy_in) begin
          next();
          roll_back = 1'b0;
          #1;
          chk("abort_idle", 32'(is_idle), 32'd1);
          chk("abort_no_pulse", 32'(finish_fetch), 32'd0);
          done = 1;
        end else if (rdy_in) begin
          p++;
        end
      end
      if (!done) next();
    end
    rdy_in = 1'b1;
    roll_back = 1'b0;
    chk("rd_completed", 32'(done), 32'd1);
  endtask

  // Starts in cycle 0 after accept; returns in the lsb_finish cycle.
  task automatic run_write(input logic [31:0] a, input int n, input logic [31:0] d,
                           input int stall_at, input int stall_n,
                           input int full_at, input int full_n);
    logic [31:0] ba;
    logic        exp_wr;
    int i;
    bit done;
    i = 0;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      rdy_in = !(c >= stall_at && c < stall_at + stall_n);
      io_buffer_full = (c >= full_at && c < full_at + full_n);
      #1;
      if (i == n) begin
        if (rdy_in) begin
          chk("wr_pulse", 32'(lsb_finish), 32'd1);
          chk("wr_finish_idle", 32'(is_idle), 32'd1);
          chk("wr_finish_mem_wr", 32'(mem_wr), 32'd0);
          done = 1;
        end else begin
          chk("wr_stalled_pulse", 32'(lsb_finish), 32'd0);
        end
      end else begin
        ba = a + 32'(i);
        exp_wr = rdy_in && !((ba[17:16] == IO_HI) && io_buffer_full);
        chk("wr_mem_wr", 32'(mem_wr), 32'(exp_wr));
        chk("wr_addr", mem_a, ba);
        chk("wr_dout", 32'(mem_dout), 32'(d[8*i +: 8]));
        chk("wr_busy_pulse", 32'(lsb_finish), 32'd0);
        if (exp_wr) begin
          refm[ba] = d[8*i +: 8];
          i++;
        end
      end
      if (!done) next();
    end
    rdy_in = 1'b1;
    io_buffer_full = 1'b0;
    chk("wr_completed", 32'(done), 32'd1);
  endtask

  // The cycle after a finish pulse: pulse gone, still idle, bus quiet.
  task automatic finish_idle();
    next();
    chk("post_fetch_pulse", 32'(finish_fetch), 32'd0);
    chk("post_lsb_pulse", 32'(lsb_finish), 32'd0);
    chk("post_idle", 32'(is_idle), 32'd1);
    chk("post_mem_wr", 32'(mem_wr), 32'd0);
  endtask

  initial begin
    int fc;
    rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0; fetch_start = 1'b0; pc_in = '0;
    lsb_start = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_data_in = '0;
    io_buffer_full = 1'b0;
    preset(32'h100, 8'h13); preset(32'h101, 8'h05); preset(32'h102, 8'h50); preset(32'h103, 8'h00);
    preset(32'h104, 8'h93); preset(32'h105, 8'h08); preset(32'h106, 8'h10); preset(32'h107, 8'h00);
    preset(32'h200, 8'h85);

    #1;
    chk("rst_idle", 32'(is_idle), 32'd1);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_inst", instruction_out, 32'd0);
    chk("rst_inst_pc", instruction_pc_out, 32'd0);
    chk("rst_ldata", lsb_data_out, 32'd0);
    chk("rst_fin_fetch", 32'(finish_fetch), 32'd0);
    chk("rst_fin_lsb", 32'(lsb_finish), 32'd0);
    next(); next();
    rst_in = 1'b0;

    // Plain word fetch.
    issue_fetch(32'h100);
    run_read(1, 32'h100, 4, -1, 0, -1, fc);
    chk("fetch_latency", 32'(fc), 32'd5);
    chk("fetch_word", instruction_out, 32'h0050_0513);
    finish_idle();

    // Simultaneous requests: load wins, fetch follows right after the finish cycle.
    wait_idle();
    lsb_start = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_len = 2'b00;
    fetch_start = 1'b1; pc_in = 32'h104;
    next();
    lsb_start = 1'b0;
    run_read(0, 32'h200, 1, -1, 0, -1, fc);
    chk("lb_latency", 32'(fc), 32'd2);
    chk("lb_data", lsb_data_out, 32'h0000_0085);
    next();
    fetch_start = 1'b0;
    chk("fetch_after_lsb_busy", 32'(is_idle), 32'd0);
    run_read(1, 32'h104, 4, -1, 0, -1, fc);
    chk("fetch2_latency", 32'(fc), 32'd5);
    finish_idle();

    // roll_back mid-fetch, then a fresh fetch.
    issue_fetch(32'h100);
    run_read(1, 32'h100, 4, -1, 0, 2, fc);
    chk("rb_no_finish", 32'(fc), 32'hffff_ffff);
    finish_idle();
    issue_fetch(32'h104);
    run_read(1, 32'h104, 4, -1, 0, -1, fc);
    chk("rb_refetch_word", instruction_out, 32'h0010_0893);
    finish_idle();

    // roll_back while idle blocks a fetch but not an LSB request (which it cannot abort).
    wait_idle();
    fetch_start = 1'b1; pc_in = 32'h100; roll_back = 1'b1;
    next();
    fetch_start = 1'b0; roll_back = 1'b0;
    chk("rb_blocks_fetch", 32'(is_idle), 32'd1);
    lsb_start = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h1000; lsb_len = 2'b10;
    fetch_start = 1'b1; roll_back = 1'b1;
    next();
    lsb_start = 1'b0; fetch_start = 1'b0; roll_back = 1'b0;
    chk("rb_lsb_accepted", 32'(is_idle), 32'd0);
    run_read(0, 32'h1000, 4, -1, 0, 1, fc);
    chk("len10_latency", 32'(fc), 32'd5);
    finish_idle();

    // IO store held off by a full buffer.
    issue_lsb(1, 32'h0003_0000, 2'b01, 32'h0000_beef);
    run_write(32'h0003_0000, 2, 32'h0000_beef, -1, 0, 0, 3);
    finish_idle();
    chk("io_byte0", 32'(ram_rd(32'h0003_0000)), 32'h0000_00ef);
    chk("io_byte1", 32'(ram_rd(32'h0003_0001)), 32'h0000_00be);

    // rdy low for 4 cycles in a word load.
    preset(32'h80, 8'hde); preset(32'h81, 8'had); preset(32'h82, 8'hbe); preset(32'h83, 8'hef);
    issue_lsb(0, 32'h80, 2'b11, 32'h0);
    run_read(0, 32'h80, 4, 1, 4, -1, fc);
    chk("stall_latency", 32'(fc), 32'd9);
    chk("stall_word", lsb_data_out, 32'hefbe_adde);
    finish_idle();

    // Half load zero-extends; word load wraps past the top of the address space.
    issue_lsb(0, 32'h104, 2'b01, 32'h0);
    run_read(0, 32'h104, 2, -1, 0, -1, fc);
    chk("lh_zero_ext", lsb_data_out, 32'h0000_0893);
    finish_idle();
    issue_lsb(0, 32'hffff_fffe, 2'b11, 32'h0);
    run_read(0, 32'hffff_fffe, 4, -1, 0, -1, fc);
    finish_idle();

    // Reset in the middle of a word store: two bytes land, then everything drops.
    issue_lsb(1, 32'h3000, 2'b11, 32'h1122_3344);
    next(); next();
    refm[32'h3000] = 8'h44;
    refm[32'h3001] = 8'h33;
    rst_in = 1'b1;
    #1;
    chk("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("mid_rst_idle", 32'(is_idle), 32'd1);
    chk("mid_rst_mem_a", mem_a, 32'd0);
    chk("mid_rst_dout", 32'(mem_dout), 32'd0);
    chk("mid_rst_inst", instruction_out, 32'd0);
    chk("mid_rst_ldata", lsb_data_out, 32'd0);
    next();
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next();
      chk("mid_rst_no_finish", 32'(lsb_finish), 32'd0);
    end
    issue_lsb(0, 32'h3000, 2'b11, 32'h0);
    run_read(0, 32'h3000, 4, -1, 0, -1, fc);
    finish_idle();

    // Randomized traffic against the reference memory.
    for (int t = 0; t < 40; t++) begin
      int kind, n, sa, sn, fa, fn, rb;
      logic [31:0] a, d;
      logic [1:0] len;
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 3) == 0) ? (32'h0003_0000 + 32'($urandom_range(0, 15)))
                                      : (32'h0000_1000 + 32'($urandom_range(0, 31)));
      len = 2'($urandom_range(0, 3));
      n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
      sa = $urandom_range(0, 6);
      sn = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      fa = $urandom_range(0, 4);
      fn = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      d = $urandom;
      if (kind == 0) begin
        issue_fetch(a);
        run_read(1, a, 4, sa, sn, rb, fc);
      end else if (kind == 1) begin
        issue_lsb(0, a, len, 32'h0);
        run_read(0, a, n, sa, sn, rb, fc);
      end else begin
        issue_lsb(1, a, len, d);
        run_write(a, n, d, sa, sn, fa, fn);
      end
      finish_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Responder end of the instruction-fetch handshake (fetch_start/pc in; is_idle/finish_fetch/instruction out) and of the load/store buffer memory port.
- Sole master of the byte-wide unified RAM bus.
- Serialises word fetches and 1/2/4-byte loads and stores into byte transactions, assembling little-endian.
- Arbitrates between fetch and LSB; aborts in-flight fetches on roll_back.

Parameters:
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the IO region; writes there honour io_buffer_full.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  ready; low freezes the block
- roll_back  input  1  misprediction flush; aborts the fetch side
- fetch_start  input  1  fetch request, sampled only while is_idle=1
- pc_in  input  32  fetch address
- is_idle  output  1  controller in IDLE, can accept a request
- finish_fetch  output  1  one-cycle pulse: instruction_out valid
- instruction_out  output  32  fetched word
- instruction_pc_out  output  32  address of fetched word
- lsb_start  input  1  LSB request, sampled only while is_idle=1
- lsb_wr  input  1  1 = store, 0 = load
- lsb_addr  input  32  byte address
- lsb_len  input  2  bytes minus 1: 00 = byte, 01 = half, 11 = word (10 illegal)
- lsb_data_in  input  32  store data, low bytes used
- lsb_finish  output  1  one-cycle pulse: load data valid or store done
- lsb_data_out  output  32  load data, zero-extended (LSB sign-extends)
- mem_din  input  8  RAM read data
- mem_dout  output  8  RAM write data
- mem_a  output  32  RAM address
- mem_wr  output  1  1 = write
- io_buffer_full  input  1  IO write buffer full

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; is_idle=1; finish_fetch=0; lsb_finish=0; instruction_out=0; instruction_pc_out=0; lsb_data_out=0; mem_a=0; mem_dout=0; mem_wr=0; byte counter=0. Reset mid-transaction drops it; no finish pulse.
- rdy_in=0: all registers hold, mem_wr forced 0, finish pulses held low. Resume exactly where stopped.
- States: IDLE, IF_READ, LSB_READ, LSB_WRITE.
- IDLE accept rule, at a rising edge with is_idle=1:
  - lsb_start=1 -> LSB_READ or LSB_WRITE.
  - else fetch_start=1 and roll_back=0 -> IF_READ.
  - LSB wins simultaneous requests.
  - Base address and length are latched on accept. pc_in is latched into instruction_pc_out.
- RAM timing: address driven in cycle t; mem_din valid in cycle t+1.
- Read of N bytes (N=4 for fetch, lsb_len+1 for load):
  - In cycle k (k=0..N-1) after accept, mem_a=base+k and mem_wr=0.
  - In cycle k (k=1..N), mem_din is captured into byte k-1 (bits 8(k-1)+7 : 8(k-1)).
  - At the edge ending cycle N, state returns to IDLE and the finish pulse asserts, with data valid in that same cycle.
  - Latency: finish pulse begins N+1 cycles after the accept edge (word: 5 cycles).
- Write of N bytes: in cycle k, mem_a=base+k, mem_dout=lsb_data_in[8k+7:8k] (latched at accept), mem_wr=1.
  - If addr[17:16]==IO_ADDR_HI and io_buffer_full=1: mem_wr=0 and the counter holds that cycle.
  - After the last byte is written: IDLE, and lsb_finish pulses the next cycle.
- is_idle=1 exactly in IDLE, including the cycle carrying a finish pulse. A new request can be accepted at the end of the finish cycle.
- Outside transactions: mem_wr=0. mem_a/mem_dout hold last value.
- roll_back:
  - In IF_READ: next edge goes to IDLE; no finish_fetch; partial data discarded.
  - In IDLE: blocks fetch accept that edge (LSB accept still allowed).
  - No effect on LSB_READ/LSB_WRITE.
  - roll_back during the finish_fetch cycle: the pulse still occurs; IF discards it.
- Address arithmetic: base+k in 32 bits, wraps mod 2^32.
- lsb_len=10 is treated as 11 (word).
- Unused load bytes: lsb_data_out upper bytes = 0.

Test Plan:
- Fetch: RAM[0x100..0x103]=13,05,50,00; fetch_start, pc_in=0x100 -> mem_a sequence 0x100..0x103, finish_fetch 1 cycle at accept+5, instruction_out=0x00500513, instruction_pc_out=0x100, is_idle back to 1.
- Simultaneous lsb_start (load byte at 0x200, RAM=0x85) and fetch_start -> LSB served first, lsb_data_out=0x00000085 at accept+2; fetch accepted on following edge, completes normally.
- roll_back at cycle 2 of fetch of 0x100 -> no finish_fetch, is_idle=1 next cycle; new fetch of 0x104 accepted and returns correct word.
- Store half 0xBEEF to 0x30000 with io_buffer_full high 3 cycles -> mem_wr low while full; then writes EF@0x30000, BE@0x30001; lsb_finish pulses once.
- rdy_in low 4 cycles mid word load at 0x80 -> mem_wr 0, no progress, correct word afterwards; latency extended by exactly 4.
- Assert rst_in mid store -> outputs to reset values immediately, mem_wr=0, no lsb_finish; next request serviced correctly.
